alu_ctrl_seq: RTL
=================

ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 Parameter FUNCT_W, default 6, width of the funct field.
REQ-002 Parameter ALUOP_W, default 4, width of the decoder ALUOp code.
REQ-003 Parameter CTRL_W, default 4, width of the ALU control code; SHALL be at least 4.
REQ-004 Parameter MUL_CYCLES, default 4, multiply latency in cycles; legal range 2..255.
REQ-005 Parameter DIV_CYCLES, default 8, divide latency in cycles; legal range 2..255.
REQ-006 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-007 rst_i  input  1  reset, synchronous and active-high.
REQ-008 valid_i  input  1  funct_i and ALUOp_i hold a valid operation.
REQ-009 funct_i  input  FUNCT_W  R-type funct field.
REQ-010 ALUOp_i  input  ALUOP_W  decoder ALUOp code.
REQ-011 ready_o  output  1  block accepts an operation this cycle.
REQ-012 valid_o  output  1  one-cycle pulse; the control outputs are final.
REQ-013 ALUCtrl_o  output  CTRL_W  registered ALU control code.
REQ-014 Sign_extend_o  output  1  registered immediate sign-extend select.
REQ-015 Mux_ALU_src1_o  output  1  registered select of shamt as ALU source 1.
REQ-016 busy_o  output  1  a multi-cycle operation is in progress.
REQ-017 illegal_o  output  1  qualified by valid_o; the accepted opcode was undefined.

Function
REQ-018 Handshake: an operation SHALL be accepted on a rising edge where valid_i=1 and ready_o=1; valid_i SHALL be ignored while ready_o=0.
REQ-019 ALUOp decode SHALL use R_TYPE=0, ADDI=1, SLTIU=2, BEQ=3, LUI=4, ORI=5, BNE=6.
REQ-020 ALU control codes SHALL be AND=0, OR=1, NAND=2, NOR=3, ADDU=4, SUBU=5, SLT=6, EQUAL=7, SRA=8, SRAV=9, LUI=10, SLTU=11, MULTU=12, DIVU=13; these values are zero-extended to CTRL_W.
REQ-021 Decode for R_TYPE funct: 0x21 ADDU, 0x23 SUBU, 0x24 AND, 0x25 OR, 0x2A SLT, 0x03 SRA, 0x07 SRAV, 0x19 MULTU, 0x1B DIVU.
REQ-022 For any R_TYPE decode, Sign_extend_o SHALL be 0, and Mux_ALU_src1_o SHALL be 1 only for funct 0x03.
REQ-023 Decode for the other ALUOp codes, given as (ALU code, Sign_extend_o): ADDI (ADDU,1), SLTIU (SLTU,0), BEQ (SUBU,1), LUI (LUI,0), ORI (OR,0), BNE (SUBU,1); Mux_ALU_src1_o SHALL be 0 for all of them.
REQ-024 An undefined ALUOp, or an undefined funct under R_TYPE, SHALL produce ALUCtrl_o=0, Sign_extend_o=0, Mux_ALU_src1_o=0 and illegal_o=1, with single-cycle timing.
REQ-025 FSM states SHALL be IDLE and MULTI, with a reset state of IDLE.
REQ-026 In IDLE, ready_o SHALL be 1 and busy_o SHALL be 0.
REQ-027 Single-cycle operation accepted at edge k: the control outputs are registered at edge k, valid_o=1 during cycle k+1, and the FSM stays in IDLE, so back-to-back accepts give one valid_o per cycle.
REQ-028 MULTU or DIVU accepted at edge k: the control outputs are registered at edge k, the FSM enters MULTI, and the down-counter loads LAT-1, where LAT is MUL_CYCLES or DIV_CYCLES.
REQ-029 In MULTI, ready_o SHALL be 0 and busy_o SHALL be 1, and the control outputs SHALL be held constant.
REQ-030 In MULTI, the counter SHALL decrement once per cycle and SHALL NOT wrap; when it reads 0, valid_o=1 in that cycle and the FSM returns to IDLE at the next edge.
REQ-031 MULTI timing: busy_o=1 in cycles k+1..k+LAT, valid_o=1 only in cycle k+LAT, and ready_o=1 again in cycle k+LAT+1.
REQ-032 The counter width SHALL be 8 bits.
REQ-033 valid_o SHALL be 0 in every cycle except the completion cycles defined by REQ-027 and REQ-031.
REQ-034 illegal_o SHALL be 0 whenever valid_o=0.

Reset
REQ-035 While rst_i=1 at an edge, the block SHALL set state=IDLE, counter=0, valid_o=0, busy_o=0, illegal_o=0, ALUCtrl_o=0, Sign_extend_o=0 and Mux_ALU_src1_o=0.
REQ-036 ready_o SHALL be 1 in the first cycle after reset is released.
REQ-037 Reset during MULTI SHALL abort the operation with no valid_o pulse.
REQ-038 rst_i SHALL take priority over valid_i arriving on the same edge; that operation is dropped.

Verification
REQ-039 Accept ALUOp=0, funct=0x03, then ADDI the next cycle -> cycle 1: ALUCtrl=8, src1=1, sext=0, valid=1; cycle 2: ALUCtrl=4, sext=1, src1=0, valid=1.
REQ-040 Accept MULTU with MUL_CYCLES=4 at edge 0 -> busy=1 in cycles 1-4, ready=0 in cycles 1-4, valid=1 only in cycle 4 with ALUCtrl=12, ready=1 in cycle 5.
REQ-041 Drive valid_i=1 with funct=0x21 during MULTI -> the operation is not accepted and no extra valid pulse appears; it is accepted in the first cycle ready=1.
REQ-042 Accept ALUOp=7 (undefined) -> next cycle valid=1, illegal=1, ALUCtrl=0, sext=0, src1=0.
REQ-043 Accept DIVU with DIV_CYCLES=8, then assert rst_i in cycle 3 -> no valid pulse; ready=1 and busy=0 in the cycle after reset is released.
REQ-044 Assert rst_i and valid_i (BEQ) on the same edge -> valid stays 0 and all outputs are 0.

Source files
------------

// File: rtl/alu_ctrl_seq.sv
// ALU control sequencer: decodes ALUOp/funct into registered ALU controls and
// stretches MULTU/DIVU into a multi-cycle busy window with a completion pulse.
module alu_ctrl_seq #(
  parameter int FUNCT_W    = 6,
  parameter int ALUOP_W    = 4,
  parameter int CTRL_W     = 4,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic [FUNCT_W-1:0] funct_i,
  input  logic [ALUOP_W-1:0] ALUOp_i,
  output logic               ready_o,
  output logic               valid_o,
  output logic [CTRL_W-1:0]  ALUCtrl_o,
  output logic               Sign_extend_o,
  output logic               Mux_ALU_src1_o,
  output logic               busy_o,
  output logic               illegal_o
);

  typedef enum logic {IDLE, MULTI} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  ctrl_q;
  logic        sext_q, src1_q, illegal_q, singleDone_q;

  logic [3:0]  decCtrl;
  logic        decSext, decSrc1, decIllegal, decMulti;
  logic [7:0]  decLat;
  logic        accept;

  assign accept = valid_i & ready_o;

  // Combinational decode of the presented operation; only used on an accept.
  always_comb begin
    decCtrl    = 4'd0;
    decSext    = 1'b0;
    decSrc1    = 1'b0;
    decIllegal = 1'b0;
    decMulti   = 1'b0;
    decLat     = 8'd0;
    case (ALUOp_i)
      ALUOP_W'(0): begin
        case (funct_i)
          FUNCT_W'(32'h21): decCtrl = 4'd4;
          FUNCT_W'(32'h23): decCtrl = 4'd5;
          FUNCT_W'(32'h24): decCtrl = 4'd0;
          FUNCT_W'(32'h25): decCtrl = 4'd1;
          FUNCT_W'(32'h2A): decCtrl = 4'd6;
          FUNCT_W'(32'h03): begin decCtrl = 4'd8; decSrc1 = 1'b1; end
          FUNCT_W'(32'h07): decCtrl = 4'd9;
          FUNCT_W'(32'h19): begin
            decCtrl  = 4'd12;
            decMulti = 1'b1;
            decLat   = 8'(MUL_CYCLES - 1);
          end
          FUNCT_W'(32'h1B): begin
            decCtrl  = 4'd13;
            decMulti = 1'b1;
            decLat   = 8'(DIV_CYCLES - 1);
          end
          default: decIllegal = 1'b1;
        endcase
      end
      ALUOP_W'(1): begin decCtrl = 4'd4;  decSext = 1'b1; end
      ALUOP_W'(2): decCtrl = 4'd11;
      ALUOP_W'(3): begin decCtrl = 4'd5;  decSext = 1'b1; end
      ALUOP_W'(4): decCtrl = 4'd10;
      ALUOP_W'(5): decCtrl = 4'd1;
      ALUOP_W'(6): begin decCtrl = 4'd5;  decSext = 1'b1; end
      default:     decIllegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter saturates at zero; the zero cycle is the completion cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept && decMulti) begin
          state_d = MULTI;
          cnt_d   = decLat;
        end
      end
      MULTI: begin
        if (cnt_q == 8'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_o   = (state_q == IDLE);
    busy_o    = (state_q == MULTI);
    valid_o   = singleDone_q | ((state_q == MULTI) && (cnt_q == 8'd0));
    illegal_o = valid_o & illegal_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q       <= 4'd0;
      sext_q       <= 1'b0;
      src1_q       <= 1'b0;
      illegal_q    <= 1'b0;
      singleDone_q <= 1'b0;
    end else begin
      singleDone_q <= accept & ~decMulti;
      if (accept) begin
        ctrl_q    <= decCtrl;
        sext_q    <= decSext;
        src1_q    <= decSrc1;
        illegal_q <= decIllegal;
      end
    end
  end

  assign ALUCtrl_o      = CTRL_W'(ctrl_q);
  assign Sign_extend_o  = sext_q;
  assign Mux_ALU_src1_o = src1_q;

endmodule
